custom_buff_use_ctrl: RTL and testbench

//  Upstream write controller for the custom buffer bank: 4 buffers x 4 entries.

---
 rtl/custom_buff_use_ctrl.sv | 160 ++++++++++++++++
 tb/tb_custom_buff_use_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/custom_buff_use_ctrl.sv
// Upstream write controller for a 4x4 custom buffer bank: per-buffer FILL/FULL/DRAIN
// tracking and a registered one-hot buff_use pulse. Optional error flag: CUSTOM_BUFF_USE_ERR_EN.
module custom_buff_use_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_buf_id,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        drain_req,
  output logic [3:0]        buff_use,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        buf_full,
  output logic [3:0]        buf_drain,
  output logic              err_flag
);

  localparam int NBUF    = 4;
  localparam int TIMER_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [2:0]         CNT_FULL   = 3'd4;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DRAIN_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  // Per-buffer FSM state, visible on buf_full / buf_drain (FILL = neither bit set).
  logic [1:0]         state_q [NBUF];
  logic [1:0]         state_d [NBUF];
  logic [2:0]         cnt_q   [NBUF];
  logic [2:0]         cnt_d   [NBUF];
  logic [TIMER_W-1:0] timer_q [NBUF];
  logic [TIMER_W-1:0] timer_d [NBUF];

  logic [NBUF-1:0]   buff_use_q;
  logic [NBUF-1:0]   buff_use_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;

  logic [NBUF-1:0] fill_mask;
  logic [NBUF-1:0] sel_oh;
  logic            accept;

  // Handshake: a word transfers on a rising edge where in_valid & in_ready.
  // in_ready depends only on the addressed buffer's state, never on in_valid.
  always_comb begin
    for (int b = 0; b < NBUF; b++) begin
      fill_mask[b] = (state_q[b] == ST_FILL);
    end
  end

  assign in_ready = fill_mask[in_buf_id];
  assign accept   = in_valid & in_ready;
  assign sel_oh   = 4'b0001 << in_buf_id;

  always_comb begin
    for (int b = 0; b < NBUF; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      timer_d[b] = timer_q[b];
      case (state_q[b])
        ST_FILL: begin
          if (accept && sel_oh[b]) begin
            cnt_d[b] = cnt_q[b] + 3'd1;
            if (cnt_q[b] + 3'd1 == CNT_FULL) begin
              state_d[b] = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (drain_req[b]) begin
            state_d[b] = ST_DRAIN;
            timer_d[b] = TIMER_LOAD;
          end
        end
        ST_DRAIN: begin
          // Returning to FILL with cnt=0 lines up with the downstream slot counter wrap.
          if (timer_q[b] == '0) begin
            state_d[b] = ST_FILL;
            cnt_d[b]   = 3'd0;
          end else begin
            timer_d[b] = timer_q[b] - TIMER_ONE;
          end
        end
        default: begin
          state_d[b] = ST_FILL;
          cnt_d[b]   = 3'd0;
          timer_d[b] = '0;
        end
      endcase
    end
  end

  always_comb begin
    buff_use_d = '0;
    out_data_d = out_data_q;
    if (accept) begin
      buff_use_d = sel_oh;
      out_data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NBUF; b++) begin
        state_q[b] <= ST_FILL;
        cnt_q[b]   <= 3'd0;
        timer_q[b] <= '0;
      end
      buff_use_q <= '0;
      out_data_q <= '0;
    end else begin
      for (int b = 0; b < NBUF; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
        timer_q[b] <= timer_d[b];
      end
      buff_use_q <= buff_use_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    for (int b = 0; b < NBUF; b++) begin
      buf_full[b]  = (state_q[b] == ST_FULL);
      buf_drain[b] = (state_q[b] == ST_DRAIN);
    end
  end

  assign buff_use = buff_use_q;
  assign out_data = out_data_q;

`ifdef CUSTOM_BUFF_USE_ERR_EN
  logic err_q;
  logic err_d;

  // Error events: a write attempt to a blocked buffer, or a drain request to a filling one.
  always_comb begin
    err_d = err_q | (in_valid & ~in_ready) | (|(drain_req & fill_mask));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_custom_buff_use_ctrl.sv
// Bench for custom_buff_use_ctrl: directed scenarios then randomized traffic,
// checked against a buffer-occupancy model and a data scoreboard.
module tb_custom_buff_use_ctrl;

  localparam int DATA_W    = 8;
  localparam int DRAIN_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_buf_id;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        drain_req;
  logic [3:0]        buff_use;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        buf_full;
  logic [3:0]        buf_drain;
  logic              err_flag;

  custom_buff_use_ctrl #(.DATA_W(DATA_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_buf_id (in_buf_id),
    .in_data   (in_data),
    .drain_req (drain_req),
    .buff_use  (buff_use),
    .out_data  (out_data),
    .buf_full  (buf_full),
    .buf_drain (buf_drain),
    .err_flag  (err_flag)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: words held per buffer, cycles of drain still to go
  logic [DATA_W-1:0] exp_q[$];
  int   occ        [4];
  int   drain_left [4];
  int   pulse_cnt  [4];
  logic err_m;

  function automatic logic m_fill(input int b);
    return (drain_left[b] == 0) && (occ[b] < 4);
  endfunction

  function automatic logic m_full(input int b);
    return (drain_left[b] == 0) && (occ[b] == 4);
  endfunction

  function automatic logic exp_err();
`ifdef CUSTOM_BUFF_USE_ERR_EN
    return err_m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      occ[b]        = 0;
      drain_left[b] = 0;
      pulse_cnt[b]  = 0;
    end
    err_m = 1'b0;
    exp_q.delete();
  endtask

  // scoreboard side: compare registered outputs against the model
  task automatic check_outputs(input logic [3:0] exp_use);
    logic [3:0] ef;
    logic [3:0] ed;
    for (int b = 0; b < 4; b++) begin
      ef[b] = m_full(b);
      ed[b] = (drain_left[b] > 0);
    end
    chk("buf_full", buf_full, ef);
    chk("buf_drain", buf_drain, ed);
    chk("err_flag", err_flag, exp_err());
    chk("buff_use", buff_use, exp_use);
    chk("onehot", ($countones(buff_use) <= 1), 1);
    if (exp_use != 4'b0000) begin
      chk("out_data", out_data, exp_q.pop_front());
    end
    for (int b = 0; b < 4; b++) begin
      if (buff_use[b]) pulse_cnt[b]++;
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic step(input logic v, input logic [1:0] id, input logic [DATA_W-1:0] d,
                      input logic [3:0] dr);
    logic       acc;
    logic       evt;
    logic [3:0] exp_use;
    logic       was_fill [4];
    logic       was_full [4];
    in_valid  = v;
    in_buf_id = id;
    in_data   = d;
    drain_req = dr;
    #1;
    chk("in_ready", in_ready, m_fill(int'(id)));
    for (int b = 0; b < 4; b++) begin
      was_fill[b] = m_fill(b);
      was_full[b] = m_full(b);
    end
    acc = v && was_fill[id];
    evt = v && !was_fill[id];
    for (int b = 0; b < 4; b++) begin
      if (dr[b] && was_fill[b]) evt = 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      if (drain_left[b] > 0) begin
        drain_left[b]--;
        if (drain_left[b] == 0) occ[b] = 0;
      end else if (was_full[b] && dr[b]) begin
        chk("pulses_per_fill", pulse_cnt[b], 4);
        pulse_cnt[b]  = 0;
        drain_left[b] = DRAIN_CYC;
      end else if (acc && (int'(id) == b)) begin
        occ[b]++;
      end
    end
    exp_use = acc ? (4'b0001 << id) : 4'b0000;
    if (acc) exp_q.push_back(d);
    if (evt) err_m = 1'b1;
    @(posedge clk);
    #1;
    check_outputs(exp_use);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, 4'b0000);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_buf_id = 2'd0;
    in_data   = '0;
    drain_req = 4'b0000;
    #1;
    model_reset();
    chk("rst_buff_use", buff_use, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_buf_drain", buf_drain, 0);
    chk("rst_err_flag", err_flag, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    do_reset();

    // four accepts to buffer 2
    step(1'b1, 2'd2, 8'h11, 4'b0000);
    step(1'b1, 2'd2, 8'h22, 4'b0000);
    step(1'b1, 2'd2, 8'h33, 4'b0000);
    step(1'b1, 2'd2, 8'h44, 4'b0000);
    chk("t2_full", buf_full, 4'b0100);
    in_buf_id = 2'd2;
    #1;
    chk("t2_ready", in_ready, 0);

    // drain buffer 2 for DRAIN_CYC cycles, then accept again
    step(1'b0, 2'd2, '0, 4'b0100);
    for (int i = 0; i < DRAIN_CYC; i++) begin
      chk("t3_drain", buf_drain[2], 1);
      idle();
    end
    chk("t3_back_fill", buf_drain[2], 0);
    step(1'b1, 2'd2, 8'h55, 4'b0000);

    // buffer 0 full, ids alternate 0/1
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 8'(8'hA0 + i), 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b1, 2'(i % 2), 8'($urandom), 4'b0000);
    chk("t4_no_use0", buff_use[0], 0);

    // drain_req on all buffers with only buffer 3 full
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 8'(8'hC0 + i), 4'b0000);
    step(1'b0, 2'd0, '0, 4'b1111);
    chk("t5_drain", buf_drain, 4'b1000);
    for (int i = 0; i < DRAIN_CYC; i++) idle();

    // reset in the middle of buffer 1 drain
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 8'(8'h60 + i), 4'b0000);
    step(1'b0, 2'd1, '0, 4'b0010);
    idle();
    chk("t6_mid_drain", buf_drain, 4'b0010);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 8'(8'h70 + i), 4'b0000);
    chk("t6_refill", buf_full, 4'b0010);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      logic [3:0] dr;
      for (int b = 0; b < 4; b++) dr[b] = ($urandom_range(0, 99) < 8);
      step(($urandom_range(0, 99) < 70), 2'($urandom_range(0, 3)), 8'($urandom), dr);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
